// File: rtl/encoder_rpm_meter.sv
// Encoder speed meter: times tick-to-tick periods and divides 60*f/ticks_per_rev by them.
// Optional macro RPM_FILTER_EN adds a 4-measurement moving average on the output.
module encoder_rpm_meter #(
   parameter int unsigned CLK_FREQ_HZ    = 25_000_000,
   parameter int unsigned TICKS_PER_REV  = 1,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ticks,
   output logic [14:0] rpm
);

   localparam longint unsigned NUM_WIDE =
      (64'(60) * 64'(CLK_FREQ_HZ)) / 64'(TICKS_PER_REV);
   localparam logic [31:0] NUM     = NUM_WIDE[31:0];
   localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);
   localparam logic [31:0] Q_MAX   = 32'd32767;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_DONE
   } state_t;

   logic        sync1_reg;
   logic        sync2_reg;
   logic        hist_reg;
   logic [31:0] cnt_reg;
   logic        armed_reg;
   state_t      state_reg;
   logic [4:0]  bit_cnt_reg;
   logic [31:0] rem_reg;
   logic [31:0] quo_reg;
   logic [31:0] divisor_reg;
   logic [14:0] rpm_reg;

   logic        edge_pulse;
   logic        timeout;
   logic [32:0] shifted;
   logic        sub_ok;
   logic [31:0] rem_next;
   logic [14:0] sat_q;
   logic [14:0] result;

   assign edge_pulse = sync2_reg & ~hist_reg;
   // An edge on the saturation cycle wins so that it can re-arm the meter.
   assign timeout    = (cnt_reg == TIMEOUT) && !edge_pulse;

   // One restoring-division step: shift in the next dividend bit and try to subtract.
   always_comb begin
      shifted  = {rem_reg, quo_reg[31]};
      sub_ok   = (shifted >= {1'b0, divisor_reg});
      rem_next = sub_ok ? 32'(shifted - {1'b0, divisor_reg}) : shifted[31:0];
      sat_q    = (quo_reg > Q_MAX) ? 15'h7FFF : quo_reg[14:0];
   end

`ifdef RPM_FILTER_EN
   logic [14:0] avg_hist_reg [3];
   logic [16:0] avg_sum;

   always_comb begin
      avg_sum = 17'(sat_q) + 17'(avg_hist_reg[0]) + 17'(avg_hist_reg[1])
              + 17'(avg_hist_reg[2]);
      result  = avg_sum[16:2];
   end

   always_ff @(posedge clk) begin
      if (rst || timeout) begin
         for (int i = 0; i < 3; i++) avg_hist_reg[i] <= '0;
      end else if (state_reg == S_DONE) begin
         avg_hist_reg[0] <= sat_q;
         avg_hist_reg[1] <= avg_hist_reg[0];
         avg_hist_reg[2] <= avg_hist_reg[1];
      end
   end
`else
   assign result = sat_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg   <= 1'b0;
         sync2_reg   <= 1'b0;
         hist_reg    <= 1'b0;
         cnt_reg     <= '0;
         armed_reg   <= 1'b0;
         state_reg   <= S_IDLE;
         bit_cnt_reg <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         divisor_reg <= '0;
         rpm_reg     <= '0;
      end else begin
         sync1_reg <= ticks;
         sync2_reg <= sync1_reg;
         hist_reg  <= sync2_reg;

         if (edge_pulse)
            cnt_reg <= '0;
         else if (cnt_reg != TIMEOUT)
            cnt_reg <= cnt_reg + 32'd1;

         if (timeout) begin
            armed_reg <= 1'b0;
            state_reg <= S_IDLE;
            rpm_reg   <= '0;
         end else begin
            if (edge_pulse && !armed_reg)
               armed_reg <= 1'b1;

            case (state_reg)
               S_IDLE: begin
                  if (edge_pulse && armed_reg) begin
                     divisor_reg <= cnt_reg + 32'd1;
                     rem_reg     <= '0;
                     quo_reg     <= NUM;
                     bit_cnt_reg <= '0;
                     state_reg   <= S_DIV;
                  end
               end
               S_DIV: begin
                  rem_reg     <= rem_next;
                  quo_reg     <= {quo_reg[30:0], sub_ok};
                  bit_cnt_reg <= bit_cnt_reg + 5'd1;
                  if (bit_cnt_reg == 5'd31)
                     state_reg <= S_DONE;
               end
               S_DONE: begin
                  rpm_reg   <= result;
                  state_reg <= S_IDLE;
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

   assign rpm = rpm_reg;

endmodule

// File: tb/tb_encoder_rpm_meter.sv
// Directed bench for encoder_rpm_meter with a scaled clock (NUM = 60*50000/2 = 1_500_000)
// so that 120 rpm is a 12_500-cycle period and the timeout is 15_000 cycles.
module tb_encoder_rpm_meter;

   localparam int unsigned NUM_B   = 1_500_000;
   localparam int unsigned T_OUT   = 15_000;
   localparam int unsigned LATENCY = 36;   // drive cycle -> rpm visible (3 sync + 33 divide)

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ticks = 1'b0;
   logic [14:0] rpm;

   int checks = 0;
   int failures = 0;

   int unsigned exp_q[$];
   bit          m_armed = 1'b0;
   int unsigned m_rpm = 0;
   int unsigned m_h [3] = '{0, 0, 0};
   int unsigned prev_dur = 0;

   encoder_rpm_meter #(
      .CLK_FREQ_HZ   (50_000),
      .TICKS_PER_REV (2),
      .TIMEOUT_CYCLES(T_OUT)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .ticks(ticks),
      .rpm  (rpm)
   );

   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_armed = 1'b0;
      m_rpm   = 0;
      for (int i = 0; i < 3; i++) m_h[i] = 0;
   endtask

   // Reference behaviour for one rising edge, given the interval since the previous one.
   function automatic int unsigned model_edge(input int unsigned interval);
      int unsigned q;
      if (!m_armed) begin
         m_armed = 1'b1;
      end else begin
         q = NUM_B / interval;
         if (q > 32767) q = 32767;
`ifdef RPM_FILTER_EN
         m_rpm  = (q + m_h[0] + m_h[1] + m_h[2]) / 4;
         m_h[2] = m_h[1];
         m_h[1] = m_h[0];
         m_h[0] = q;
`else
         m_rpm = q;
`endif
      end
      return m_rpm;
   endfunction

   // Rising edge now, check rpm just before and exactly at the expected update, then fill
   // the rest of the interval so the next call's edge is dur cycles after this one.
   task automatic run_edge(input string tag, input int unsigned dur);
      int unsigned old_rpm;
      int unsigned exp;
      old_rpm = m_rpm;
      ticks = 1'b1;
      exp_q.push_back(model_edge(prev_dur));
      cyc(LATENCY - 1);
      check({tag, "_hold"}, 32'(rpm), old_rpm);
      cyc(1);
      exp = exp_q.pop_front();
      check(tag, 32'(rpm), exp);
      $display("edge %s interval=%0d rpm=%0d expected=%0d", tag, prev_dur, rpm, exp);
      ticks = 1'b0;
      cyc(dur - LATENCY);
      prev_dur = dur;
   endtask

   initial begin
      // Reset and idle
      cyc(3);
      rst = 1'b0;
      check("reset_rpm", 32'(rpm), 0);
      for (int i = 0; i < 10; i++) begin
         cyc(100);
         check("idle_rpm", 32'(rpm), 0);
      end

      // 120 rpm: first edge only arms
      for (int i = 0; i < 5; i++) run_edge("rpm120", 12_500);

      // Stop ticks: rpm drops exactly TIMEOUT cycles after the launch of the last edge
      cyc(T_OUT + 3 - 12_500);
      check("timeout_before", 32'(rpm), m_rpm);
      cyc(1);
      model_clear();
      check("timeout_zero", 32'(rpm), 0);
      $display("timeout rpm=%0d", rpm);

      // Single edge after timeout only re-arms
      run_edge("rearm", 250);
      for (int i = 0; i < 4; i++) run_edge("rpm6000", 250);

      // 40-cycle period: first measures 250, the rest saturate
      for (int i = 0; i < 3; i++) run_edge("sat", 40);

      // Reset pulse while the divider is in its DIV state
      ticks = 1'b1;
      cyc(5);
      ticks = 1'b0;
      cyc(7);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      model_clear();
      cyc(30);
      check("rst_mid_div", 32'(rpm), 0);
      $display("reset mid-division rpm=%0d", rpm);
      cyc(250 - 43);
      prev_dur = 250;
      run_edge("post_rst_arm", 250);
      run_edge("post_rst", 250);

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/encoder_rpm_meter.md
Name: encoder_rpm_meter

Overview:
- Measures shaft speed from a single-phase encoder tick input by timing the clk-cycle period between consecutive tick rising edges.
- Converts each period to revolutions per minute with an iterative divider and presents the result as a 15-bit unsigned value.
- Sits between the raw encoder pin and motor-control / telemetry logic.
- Target system clock is 25 MHz (40 ns period).

Parameters:
- CLK_FREQ_HZ, 25_000_000, frequency of clk in Hz.
- TICKS_PER_REV, 1, encoder rising edges per shaft revolution.
- TIMEOUT_CYCLES, 50_000_000, cycles without an edge before speed is declared zero (2 s).
- Constant NUM = 60*CLK_FREQ_HZ/TICKS_PER_REV, computed at elaboration.
  - 1_500_000_000 at defaults.
  - Must fit in 32 bits.

Ports:
- clk, input, 1, system clock; all logic rising-edge.
- rst, input, 1, reset; synchronous, active-high.
- ticks, input, 1, asynchronous encoder pulse; one rising edge per count.
- rpm, output, 15, unsigned speed in rev/min, registered.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rpm=0; synchronizer, period counter, divider and armed flag all cleared.
  - Reset mid-division aborts the division; no stale result is ever written.
- Input synchronizer:
  - ticks passes through a 2-flop synchronizer plus a third history flop.
  - Edge pulse = sync & ~hist, one cycle wide.
  - Only rising edges count; falling edges are ignored.
- Period counter:
  - 32-bit; increments every cycle; saturates at TIMEOUT_CYCLES.
  - On an edge pulse: capture the current count+1 as period, then restart the counter at 0.
- Armed flag:
  - The first edge after reset or after a timeout only sets the armed flag; no division starts.
  - Each subsequent edge, with armed=1 and the divider idle, launches a division NUM/period.
- Divider:
  - Restoring, 32-bit, one quotient bit per cycle, states IDLE -> DIV (32 cycles) -> DONE (1 cycle) -> IDLE.
  - rpm is updated in the DONE cycle, i.e. 33 clk cycles after the edge-pulse cycle.
  - Result is saturated: quotient > 32767 gives rpm=32767.
- Edge arriving while the divider is busy:
  - The period counter still restarts.
  - That measurement is dropped; rpm keeps its last value until the next accepted edge.
- Timeout:
  - When the period counter reaches TIMEOUT_CYCLES, rpm=0 on the next cycle and armed is cleared.
  - rpm stays 0 until two further edges have been seen.
- Truncation: integer floor division; no rounding.

Optional Feature:
- Macro RPM_FILTER_EN.
- Defined:
  - Each saturated quotient is pushed into a 4-entry history.
  - rpm = floor(sum of 4 entries / 4), with a 17-bit sum, updated in the same DONE cycle.
  - History is cleared to 0 on reset and on timeout, so output ramps up over 4 measurements.
- Not defined:
  - rpm is the raw saturated quotient; no history registers are synthesized.

Test Plan:
- Reset, then hold ticks=0 for 1000 cycles -> rpm=0 throughout.
- ticks toggling every 250 ms (period 12_500_000 cycles):
  - First rising edge -> rpm stays 0.
  - 33 cycles after the second rising edge -> rpm=120; remains 120 on later edges.
  - With RPM_FILTER_EN, rpm goes 30, 60, 90, 120 over successive edges.
- Rising-edge period 250_000 cycles (10 ms) -> rpm=6000.
- Rising-edge period 40 cycles (quotient 37_500_000) -> rpm saturates at 32767.
- Run at 120 rpm, then stop ticks -> rpm=0 exactly 50_000_000 cycles after the last edge; the next single edge leaves rpm=0.
- Assert rst for 1 cycle during the DIV state -> rpm=0 afterwards; the next edge only arms; the second edge yields the correct value.
